// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared sizing for the sync FIFO pointer controller.
// CFG_FIFO_DEPTH can be overridden globally and must be a power of two.
`ifndef CFG_FIFO_DEPTH
`define CFG_FIFO_DEPTH 16
`endif

package fifo_ptr_ctrl_pkg;

  localparam int DEFAULT_FIFO_DEPTH = `CFG_FIFO_DEPTH;
  localparam int DEFAULT_ADDR_WIDTH = $clog2(DEFAULT_FIFO_DEPTH);
  localparam int DEFAULT_PTR_WIDTH  = DEFAULT_ADDR_WIDTH + 1;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/fifo_out_buf2.sv
// Two-entry first-word-fall-through buffer that sits after the RAM read port.
// It absorbs one word of RAM read latency so the output can stream without bubbles.
module fifo_out_buf2 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] entry [2];
  logic                  rd_idx;
  logic                  wr_idx;
  logic                  pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = (count != 2'd0) ? entry[rd_idx] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry[0] <= '0;
      entry[1] <= '0;
      rd_idx   <= 1'b0;
      wr_idx   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (push) begin
        entry[wr_idx] <= din;
        wr_idx        <= ~wr_idx;
      end
      if (pop_ok) begin
        rd_idx <= ~rd_idx;
      end
      count <= count + {1'b0, push} - {1'b0, pop_ok};
    end
  end

  // The read issuer never lets occupancy exceed two, so a push into a full buffer is a bug upstream.
  assert property (@(posedge clk) disable iff (!reset_n) !(push && !pop_ok && count == 2'd2));

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and handshake controller for the sync FIFO: drives a 1-cycle-latency RAM,
// exports wrap-extended pointers for the flag comparator and a total occupancy count.
module fifo_ptr_ctrl
  import fifo_ptr_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid_s,
  input  logic [DATA_WIDTH-1:0] i_data_s,
  output logic                  o_ready_s,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_re,
  output logic [ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_valid_m,
  output logic [DATA_WIDTH-1:0] o_data_m,
  input  logic                  i_ready_m,
  output logic [ADDR_WIDTH:0]   o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_rd_addr,
  output logic [ADDR_WIDTH+1:0] o_count
);

  localparam int PTR_WIDTH = ADDR_WIDTH + 1;
  localparam int CNT_WIDTH = ADDR_WIDTH + 2;
  localparam logic [PTR_WIDTH-1:0] DEPTH_PTR = PTR_WIDTH'(FIFO_DEPTH);

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH-1:0] ram_used;
  logic [CNT_WIDTH-1:0] count;
  logic                 in_flight;
  logic                 ram_full;
  logic                 ram_empty;
  logic                 pop;
  logic [1:0]           buf_cnt;
  logic [1:0]           occ;

  // The wrap bit makes a full RAM (difference == depth) distinct from an empty one.
  assign ram_used  = wr_ptr - rd_ptr;
  assign ram_full  = (ram_used == DEPTH_PTR);
  assign ram_empty = (ram_used == '0);

  assign o_ready_s   = !ram_full;
  assign o_mem_we    = i_valid_s && o_ready_s;
  assign o_mem_waddr = wr_ptr[ADDR_WIDTH-1:0];
  assign o_mem_wdata = i_data_s;

  assign o_valid_m = (buf_cnt != 2'd0);
  assign pop       = o_valid_m && i_ready_m;

  // A pop frees a slot this cycle, so a read can be issued even when buffer plus in-flight is two.
  assign occ         = buf_cnt + {1'b0, in_flight};
  assign o_mem_re    = !ram_empty && ((occ < 2'd2) || pop);
  assign o_mem_raddr = rd_ptr[ADDR_WIDTH-1:0];

  assign o_wr_addr = wr_ptr;
  assign o_rd_addr = rd_ptr;
  assign o_count   = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_flight <= 1'b0;
      count     <= '0;
    end else begin
      if (o_mem_we) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (o_mem_re) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      in_flight <= o_mem_re;
      count     <= count + CNT_WIDTH'(o_mem_we) - CNT_WIDTH'(pop);
    end
  end

  fifo_out_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_flight),
    .din     (i_mem_rdata),
    .pop     (pop),
    .count   (buf_cnt),
    .head    (o_data_m)
  );

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: a behavioural RAM fixture plus a word-level
// reference model (accepted/issued/popped totals and a data queue).
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid_s = 1'b0;
  logic [DW-1:0] i_data_s = '0;
  logic          o_ready_s;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_waddr;
  logic [DW-1:0] o_mem_wdata;
  logic          o_mem_re;
  logic [AW-1:0] o_mem_raddr;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          o_valid_m;
  logic [DW-1:0] o_data_m;
  logic          i_ready_m = 1'b0;
  logic [AW:0]   o_wr_addr;
  logic [AW:0]   o_rd_addr;
  logic [AW+1:0] o_count;

  int n_vectors = 0;
  int n_miscompares = 0;

  // Reference model state: lifetime totals and the words currently held, oldest first.
  int            m_wr_total;
  int            m_rd_total;
  int            m_buf_cnt;
  bit            m_infl;
  logic [DW-1:0] exp_q[$];

  logic [DW-1:0] ram [DEPTH];

  fifo_ptr_ctrl #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_valid_s   (i_valid_s),
    .i_data_s    (i_data_s),
    .o_ready_s   (o_ready_s),
    .o_mem_we    (o_mem_we),
    .o_mem_waddr (o_mem_waddr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_re    (o_mem_re),
    .o_mem_raddr (o_mem_raddr),
    .i_mem_rdata (i_mem_rdata),
    .o_valid_m   (o_valid_m),
    .o_data_m    (o_data_m),
    .i_ready_m   (i_ready_m),
    .o_wr_addr   (o_wr_addr),
    .o_rd_addr   (o_rd_addr),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_we) ram[o_mem_waddr] <= o_mem_wdata;
    if (o_mem_re) i_mem_rdata <= ram[o_mem_raddr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic void modelReset();
    m_wr_total = 0;
    m_rd_total = 0;
    m_buf_cnt  = 0;
    m_infl     = 1'b0;
    exp_q.delete();
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 32'(o_ready_s), 32'd1);
    checkOutput({tag, "_valid"}, 32'(o_valid_m), 32'd0);
    checkOutput({tag, "_we"},    32'(o_mem_we),  32'd0);
    checkOutput({tag, "_re"},    32'(o_mem_re),  32'd0);
    checkOutput({tag, "_count"}, 32'(o_count),   32'd0);
    checkOutput({tag, "_data"},  32'(o_data_m),  32'd0);
    checkOutput({tag, "_wrptr"}, 32'(o_wr_addr), 32'd0);
    checkOutput({tag, "_rdptr"}, 32'(o_rd_addr), 32'd0);
  endtask

  task automatic doReset();
    i_valid_s = 1'b0;
    i_ready_m = 1'b0;
    i_data_s  = '0;
    reset_n   = 1'b0;
    #1;
    modelReset();
    checkResetValues("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive one cycle of inputs at the falling edge, compare against the model, then advance it.
  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data, input logic ready);
    int used;
    bit exp_ready, exp_valid, exp_pop, exp_we, exp_re;
    @(negedge clk);
    i_valid_s = valid;
    i_data_s  = data;
    i_ready_m = ready;
    #1;
    used      = m_wr_total - m_rd_total;
    exp_ready = (used != DEPTH);
    exp_valid = (m_buf_cnt > 0);
    exp_pop   = exp_valid && ready;
    exp_we    = valid && exp_ready;
    exp_re    = (used > 0) && ((m_buf_cnt + (m_infl ? 1 : 0)) < 2 || exp_pop);

    checkOutput("ready_s", 32'(o_ready_s), 32'(exp_ready));
    checkOutput("valid_m", 32'(o_valid_m), 32'(exp_valid));
    checkOutput("mem_we",  32'(o_mem_we),  32'(exp_we));
    checkOutput("mem_re",  32'(o_mem_re),  32'(exp_re));
    checkOutput("wr_addr", 32'(o_wr_addr), 32'(m_wr_total % (2 * DEPTH)));
    checkOutput("rd_addr", 32'(o_rd_addr), 32'(m_rd_total % (2 * DEPTH)));
    checkOutput("count",   32'(o_count),   32'(exp_q.size()));
    checkOutput("data_m",  32'(o_data_m),  exp_valid ? 32'(exp_q[0]) : 32'd0);
    if (exp_we) begin
      checkOutput("mem_waddr", 32'(o_mem_waddr), 32'(m_wr_total % DEPTH));
      checkOutput("mem_wdata", 32'(o_mem_wdata), 32'(data));
    end
    if (exp_re) begin
      checkOutput("mem_raddr", 32'(o_mem_raddr), 32'(m_rd_total % DEPTH));
    end

    if (exp_pop) void'(exp_q.pop_front());
    if (exp_we) exp_q.push_back(data);
    m_buf_cnt  = m_buf_cnt + (m_infl ? 1 : 0) - (exp_pop ? 1 : 0);
    m_infl     = exp_re;
    m_wr_total = m_wr_total + (exp_we ? 1 : 0);
    m_rd_total = m_rd_total + (exp_re ? 1 : 0);
  endtask

  initial begin
    int first_ready;
    bit got_first;
    int pv, pr;

    // Reset and idle.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    // Single word through an empty FIFO with the consumer stalled.
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_re_pulse", 32'(o_mem_re), 32'd1);
    checkOutput("t2_count_e1", 32'(o_count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("t2_valid", 32'(o_valid_m), 32'd1);
    checkOutput("t2_data",  32'(o_data_m),  32'hA5);
    checkOutput("t2_count", 32'(o_count),   32'd1);

    // Fill to the brim: 16 in RAM plus 2 in the output buffer.
    doReset();
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(i + 8'h10), 1'b0);
    checkOutput("t3_ready",    32'(o_ready_s), 32'd0);
    checkOutput("t3_count",    32'(o_count),   32'd18);
    checkOutput("t3_ptr_diff", 32'(5'(o_wr_addr - o_rd_addr)), 32'd16);

    // Drain while still writing; pointers wrap past the top of the extended range.
    first_ready = -1;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      if (first_ready < 0 && o_ready_s) first_ready = i;
    end
    checkOutput("t4_ready_within_2", 32'(first_ready >= 1 && first_ready <= 2), 32'd1);

    // Streaming with both sides always ready.
    doReset();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'($urandom), 1'b1);
      if (i >= 3) checkOutput("t5_valid_steady", 32'(o_valid_m), 32'd1);
      checkOutput("t5_count_le3", 32'(o_count <= 3), 32'd1);
    end
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 1'b1);

    // Random traffic with changing producer/consumer bias.
    for (int phase = 0; phase < 5; phase++) begin
      pv = 20 + 20 * phase;
      pr = 90 - 20 * phase;
      for (int i = 0; i < 120; i++) begin
        applyStimulus(32'($urandom_range(0, 99)) < pv, 8'($urandom), 32'($urandom_range(0, 99)) < pr);
      end
    end

    // Reset with 7 words stored and a read in flight.
    doReset();
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    i_valid_s = 1'b0;
    i_ready_m = 1'b0;
    reset_n   = 1'b0;
    #1;
    checkResetValues("t6_midreset");
    modelReset();
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    got_first = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      if (!got_first && o_valid_m) begin
        checkOutput("t6_first_word", 32'(o_data_m), 32'h3C);
        got_first = 1'b1;
      end
    end
    checkOutput("t6_word_seen", 32'(got_first), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
